// File: rtl/lcm.sv
//==============================================================================
// Module      : lcm
// Description : Sequential least-common-multiple unit. It keeps two running
//               multiples, ma = i*a and mb = j*b. On each clock it adds the
//               operand to whichever multiple is smaller, and it stops when the
//               two multiples are equal. The accumulators are 2*WIDTH bits
//               wide because lcm(a,b) <= a*b, so they cannot overflow.
//               The block uses a start/busy/done handshake. The result is held
//               until the next accepted start.
// Ports       : clk    - rising-edge clock
//               rst    - asynchronous active-low reset (0 = reset)
//               start  - job request, accepted only in IDLE or DONE
//               a, b   - WIDTH-bit operands, captured on the accepted start
//               busy   - high while the additions are running
//               done   - one-cycle pulse, the cycle after the result lands
//               opt    - 2*WIDTH-bit LCM result
//               iters  - WIDTH+1-bit addition count (LCM_ITER_CNT_EN only)
// Options     : `define LCM_ITER_CNT_EN adds the iters output and its counter.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module lcm #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
`ifdef LCM_ITER_CNT_EN
  output logic [WIDTH:0]       iters,
`endif
  output logic [2*WIDTH-1:0]   opt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [WIDTH-1:0]     r_ra;
  logic [WIDTH-1:0]     r_rb;
  logic [2*WIDTH-1:0]   r_ma;
  logic [2*WIDTH-1:0]   r_mb;
  logic [2*WIDTH-1:0]   r_opt;
  logic                 r_enter;     // DONE was entered on the previous edge
  logic                 r_done;
  logic                 w_accept;
  logic                 w_zero;
  logic                 w_eq;
  logic                 w_add;
  logic                 w_enter_done;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_zero   = (a == '0) || (b == '0);
  assign w_eq     = (r_ma == r_mb);
  assign w_add    = (r_state == S_RUN) && !w_eq;

  always_comb begin
    w_next_state = r_state;
    w_enter_done = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          // A zero operand has lcm 0, so it goes straight to DONE with no additions.
          w_next_state = w_zero ? S_DONE : S_RUN;
          w_enter_done = w_zero;
        end
      end
      S_RUN: begin
        if (w_eq) begin
          w_next_state = S_DONE;
          w_enter_done = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ra    <= '0;
      r_rb    <= '0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_opt   <= '0;
      r_enter <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // done follows DONE entry by one cycle. A back-to-back start still lets
      // the previous job's pulse through.
      r_enter <= w_enter_done;
      r_done  <= r_enter;
      if (w_accept) begin
        r_ra <= a;
        r_rb <= b;
        r_ma <= {{WIDTH{1'b0}}, a};
        r_mb <= {{WIDTH{1'b0}}, b};
        if (w_zero) begin
          r_opt <= '0;
        end
      end else if (r_state == S_RUN) begin
        if (w_eq) begin
          r_opt <= r_ma;
        end else if (r_ma < r_mb) begin
          r_ma <= r_ma + {{WIDTH{1'b0}}, r_ra};
        end else begin
          r_mb <= r_mb + {{WIDTH{1'b0}}, r_rb};
        end
      end
    end
  end

`ifdef LCM_ITER_CNT_EN
  logic [WIDTH:0] r_iters;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_iters <= '0;
    end else if (w_accept) begin
      r_iters <= '0;
    end else if (w_add) begin
      r_iters <= r_iters + 1'b1;
    end
  end

  assign iters = r_iters;
`endif

  assign busy = (r_state == S_RUN);
  assign done = r_done;
  assign opt  = r_opt;

endmodule

`default_nettype wire

// File: tb/tb_lcm.sv
//==============================================================================
// Module      : tb_lcm
// Description : Self-checking bench for lcm. It runs a WIDTH=8 instance so the
//               worst case (255, 254) stays short. The bench applies a
//               hand-computed vector table, two directed corner sequences
//               (start during RUN and a mid-cycle async reset), and random
//               jobs checked against an arithmetic lcm model.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lcm;

  localparam int W = 8;

  logic           clk   = 1'b0;
  logic           rst   = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a     = '0;
  logic [W-1:0]   b     = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] opt;
`ifdef LCM_ITER_CNT_EN
  logic [W:0]     iters;
`endif

  lcm #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
`ifdef LCM_ITER_CNT_EN
    .iters (iters),
`endif
    .opt   (opt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int unsigned a;
    int unsigned b;
    int unsigned opt;
    int unsigned lat;
    int unsigned it;
    int          inj;   // edge at which an ignored start is raised (0 = none)
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: lcm from gcd by plain arithmetic, addition count from multiples.
  function automatic void model(input int unsigned x, input int unsigned y,
                                output int unsigned l, output int unsigned n);
    int unsigned p, q, t;
    if (x == 0 || y == 0) begin
      l = 0;
      n = 0;
    end else begin
      p = x;
      q = y;
      while (q != 0) begin
        t = p % q;
        p = q;
        q = t;
      end
      l = (x / p) * y;
      n = l / x + l / y - 2;
    end
  endfunction

  // Called with the bench one time unit past a rising edge. That edge becomes edge 0.
  task automatic run_job(input string tag, input int unsigned x, input int unsigned y,
                         input int unsigned e_opt, input int unsigned e_lat,
                         input int unsigned e_it, input int inj);
    int  lat;
    int  busy_cnt;
    bit  seen;
    a     = W'(x);
    b     = W'(y);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    check({tag, ".done_low_at_start"}, 32'(done), 32'd0);
    busy_cnt = int'(busy);
    seen     = 1'b0;
    lat      = 0;
    for (int k = 1; k <= 1200; k++) begin
      if (k == inj) begin
        start = 1'b1;
        a     = 8'd1;
        b     = 8'd1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
      busy_cnt += int'(busy);
    end
    if (!seen) begin
      check({tag, ".timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, ".latency"}, 32'(lat), 32'(e_lat));
    check({tag, ".opt"}, 32'(opt), 32'(e_opt));
    check({tag, ".busy_cycles"}, 32'(busy_cnt), (x == 0 || y == 0) ? 32'd0 : 32'(e_it + 1));
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
`ifdef LCM_ITER_CNT_EN
    check({tag, ".iters"}, 32'(iters), 32'(e_it));
`endif
  endtask

  initial begin
    int unsigned x, y, l, n, lat;
    int          inj;

    tbl[0]  = '{a: 4,   b: 6,   opt: 12,    lat: 5,   it: 3,   inj: 0};
    tbl[1]  = '{a: 7,   b: 7,   opt: 7,     lat: 2,   it: 0,   inj: 0};
    tbl[2]  = '{a: 3,   b: 5,   opt: 15,    lat: 8,   it: 6,   inj: 0};
    tbl[3]  = '{a: 0,   b: 9,   opt: 0,     lat: 1,   it: 0,   inj: 0};
    tbl[4]  = '{a: 9,   b: 0,   opt: 0,     lat: 1,   it: 0,   inj: 0};
    tbl[5]  = '{a: 255, b: 254, opt: 64770, lat: 509, it: 507, inj: 0};
    tbl[6]  = '{a: 1,   b: 1,   opt: 1,     lat: 2,   it: 0,   inj: 0};
    tbl[7]  = '{a: 1,   b: 255, opt: 255,   lat: 256, it: 254, inj: 0};
    tbl[8]  = '{a: 0,   b: 0,   opt: 0,     lat: 1,   it: 0,   inj: 0};
    tbl[9]  = '{a: 2,   b: 3,   opt: 6,     lat: 5,   it: 3,   inj: 0};
    tbl[10] = '{a: 12,  b: 18,  opt: 36,    lat: 5,   it: 3,   inj: 2};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.opt",  32'(opt),  32'd0);
`ifdef LCM_ITER_CNT_EN
    check("reset.iters", 32'(iters), 32'd0);
`endif
    rst = 1'b1;
    @(posedge clk); #1;

    // Table vectors, back to back (each start accepted in DONE)
    for (int i = 0; i < 11; i++) begin
      run_job($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].opt,
              tbl[i].lat, tbl[i].it, tbl[i].inj);
    end

    // Async reset in the middle of a job, with opt still holding 36
    a     = 8'd12;
    b     = 8'd18;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("arst.busy", 32'(busy), 32'd0);
    check("arst.done", 32'(done), 32'd0);
    check("arst.opt",  32'(opt),  32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("arst.no_done", 32'(done), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("arst.no_done_after_release", 32'(done), 32'd0);
    run_job("post_rst", 2, 3, 6, 5, 3, 0);

    // Random jobs against the arithmetic model
    for (int r = 0; r < 40; r++) begin
      x = $urandom_range(0, 255);
      y = $urandom_range(1, 255);
      if ($urandom_range(0, 7) == 0) x = 0;
      if ($urandom_range(0, 1) == 0) begin
        l = x;
        x = y;
        y = l;
      end
      model(x, y, l, n);
      lat = (x == 0 || y == 0) ? 1 : n + 2;
      inj = 0;
      if (lat >= 2 && $urandom_range(0, 1) == 1) inj = int'($urandom_range(1, lat - 1));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      run_job($sformatf("rnd%0d_%0d_%0d", r, x, y), x, y, l, lat, n, inj);
    end

    @(posedge clk); #1;
    check("final.done_pulse_ends", 32'(done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
